// File: rtl/dispatch_pkg.sv
// rtl/dispatch_pkg.sv - shared constants, slot states and queue-meta pack/unpack helpers for the dispatch-to-issue-queue stage
package dispatch_pkg;

  localparam int DISPATCH_NUM_CH = 5;
  localparam int DISPATCH_DATA_W = 128;

  // Channel order on the dispatch bus
  localparam int CH_ALU0 = 0;
  localparam int CH_ALU1 = 1;
  localparam int CH_MDU0 = 2;
  localparam int CH_LSU0 = 3;
  localparam int CH_LSU1 = 4;

  // Occupancy of one channel: nothing, main only, main plus skid
  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'd0,
    SLOT_MAIN  = 2'd1,
    SLOT_FULL  = 2'd2
  } slot_state_e;

  typedef logic [DISPATCH_DATA_W-1:0] dispatch_data_t;

  // ALU/MDU issue-queue meta
  typedef struct packed {
    logic [5:0]  rob_id;
    logic [31:0] pc;
    logic [5:0]  prd;
    logic [5:0]  prs1;
    logic [5:0]  prs2;
    logic [31:0] imm;
    logic [4:0]  op;
  } alu_meta_t;

  // LSU issue-queue meta
  typedef struct packed {
    logic [5:0]  rob_id;
    logic [5:0]  prd;
    logic [5:0]  prs1;
    logic [5:0]  prs2;
    logic [31:0] imm;
    logic [3:0]  size_sign;
    logic        is_store;
    logic [4:0]  lq_idx;
    logic [4:0]  sq_idx;
  } lsu_meta_t;

  // Narrower metas sit in the low bits with the rest zeroed
  function automatic dispatch_data_t pack_alu(input alu_meta_t m);
    dispatch_data_t d;
    d = '0;
    d[$bits(alu_meta_t)-1:0] = m;
    return d;
  endfunction

  function automatic alu_meta_t unpack_alu(input dispatch_data_t d);
    alu_meta_t m;
    m = d[$bits(alu_meta_t)-1:0];
    return m;
  endfunction

  function automatic dispatch_data_t pack_lsu(input lsu_meta_t m);
    dispatch_data_t d;
    d = '0;
    d[$bits(lsu_meta_t)-1:0] = m;
    return d;
  endfunction

  function automatic lsu_meta_t unpack_lsu(input dispatch_data_t d);
    lsu_meta_t m;
    m = d[$bits(lsu_meta_t)-1:0];
    return m;
  endfunction

endpackage

// File: rtl/dispatch_skid_slot.sv
// rtl/dispatch_skid_slot.sv - one channel's main+skid two-entry FIFO driven by pre-gated accept/drain strobes
module dispatch_skid_slot
  import dispatch_pkg::*;
#(
  parameter int DATA_W = DISPATCH_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              accept_i,
  input  logic              drain_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              main_v_o,
  output logic              skid_v_o,
  output logic [DATA_W-1:0] main_data_o
);

  slot_state_e       state_q;
  logic [DATA_W-1:0] main_data_q;
  logic [DATA_W-1:0] skid_data_q;

  // Occupancy FSM; data registers only move on accept or skid promotion.
  // Pause needs no branch here: the top forces accept and drain low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SLOT_EMPTY;
      main_data_q <= '0;
      skid_data_q <= '0;
    end else if (flush_i) begin
      state_q <= SLOT_EMPTY;
    end else begin
      case (state_q)
        SLOT_EMPTY: begin
          if (accept_i) begin
            main_data_q <= in_data_i;
            state_q     <= SLOT_MAIN;
          end
        end
        SLOT_MAIN: begin
          if (accept_i && drain_i) begin
            main_data_q <= in_data_i;
          end else if (accept_i) begin
            skid_data_q <= in_data_i;
            state_q     <= SLOT_FULL;
          end else if (drain_i) begin
            state_q <= SLOT_EMPTY;
          end
        end
        SLOT_FULL: begin
          // in_ready is low while full, so only a drain can happen
          if (drain_i) begin
            main_data_q <= skid_data_q;
            state_q     <= SLOT_MAIN;
          end
        end
        default: state_q <= SLOT_EMPTY;
      endcase
    end
  end

  assign main_v_o    = (state_q != SLOT_EMPTY);
  assign skid_v_o    = (state_q == SLOT_FULL);
  assign main_data_o = main_data_q;

endmodule

// File: rtl/dispatch_iq_pipe.sv
// rtl/dispatch_iq_pipe.sv - NUM_CH skid-buffered dispatch-to-issue-queue channels; DISPATCH_IQ_PIPE_PERF_EN adds perf_bp_cnt
module dispatch_iq_pipe
  import dispatch_pkg::*;
#(
  parameter int NUM_CH = DISPATCH_NUM_CH,
  parameter int DATA_W = DISPATCH_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     pausereq,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [NUM_CH-1:0]        out_valid,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  input  logic [NUM_CH-1:0]        out_ready
`ifdef DISPATCH_IQ_PIPE_PERF_EN
  ,
  output logic [31:0]              perf_bp_cnt
`endif
);

  logic [NUM_CH-1:0]        main_v;
  logic [NUM_CH-1:0]        skid_v;
  logic [NUM_CH-1:0]        accept;
  logic [NUM_CH-1:0]        drain;
  logic [NUM_CH*DATA_W-1:0] main_data;
  logic                     block_in;
  logic                     block_out;

  // in_ready depends only on registered skid state plus global controls,
  // never on out_ready, so back-pressure does not ripple upstream in one cycle
  assign block_in  = rst | flush | pausereq;
  assign block_out = rst | pausereq;
  assign in_ready  = ~skid_v & {NUM_CH{~block_in}};
  assign out_valid = main_v & {NUM_CH{~block_out}};
  assign out_data  = rst ? '0 : main_data;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    dispatch_skid_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (flush),
      .accept_i   (accept[i]),
      .drain_i    (drain[i]),
      .in_data_i  (in_data[i*DATA_W +: DATA_W]),
      .main_v_o   (main_v[i]),
      .skid_v_o   (skid_v[i]),
      .main_data_o(main_data[i*DATA_W +: DATA_W])
    );
  end

`ifdef DISPATCH_IQ_PIPE_PERF_EN
  logic [31:0] perf_cnt_q;
  logic        bp_hit;

  // out_valid already excludes pause and reset, so it stands in for main_v & !pausereq
  assign bp_hit = |(out_valid & ~out_ready);

  // Saturating back-pressure cycle counter; survives flush, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt_q <= '0;
    end else if (bp_hit && (perf_cnt_q != 32'hFFFF_FFFF)) begin
      perf_cnt_q <= perf_cnt_q + 32'd1;
    end
  end

  assign perf_bp_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_dispatch_iq_pipe.sv
// tb/tb_dispatch_iq_pipe.sv - directed self-checking bench for dispatch_iq_pipe
module tb_dispatch_iq_pipe;

  localparam int N = 5;
  localparam int W = 128;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             pausereq;
  logic [N-1:0]     in_valid;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_ready;
  logic [N-1:0]     out_valid;
  logic [N*W-1:0]   out_data;
  logic [N-1:0]     out_ready;
`ifdef DISPATCH_IQ_PIPE_PERF_EN
  logic [31:0]      perf_bp_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  dispatch_iq_pipe #(.NUM_CH(N), .DATA_W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .pausereq (pausereq),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready)
`ifdef DISPATCH_IQ_PIPE_PERF_EN
    ,
    .perf_bp_cnt(perf_bp_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] od(input int ch);
    return out_data[ch*W +: W];
  endfunction

  task automatic set_data(input int ch, input logic [W-1:0] v);
    in_data[ch*W +: W] = v;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; pausereq = 1'b0;
    in_valid = '0; in_data = '0; out_ready = '0;

    // reset cycle
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(5'h00));
    chk("rst_out_valid", 128'(out_valid), 128'(5'h00));
    chk("rst_out_data", 128'(out_data == '0), 128'(1'b1));
    tick;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 128'(in_ready), 128'(5'h1F));
    chk("post_rst_out_valid", 128'(out_valid), 128'(5'h00));

    // pass-through on ch0
    out_ready = 5'h1F;
    in_valid = 5'b00001; set_data(0, 128'h11);
    #1;
    chk("pt_in_ready_pre", 128'(in_ready), 128'(5'h1F));
    tick;
    in_valid = '0;
    #1;
    chk("pt_out_valid", 128'(out_valid), 128'(5'b00001));
    chk("pt_out_data", od(0), 128'h11);
    chk("pt_in_ready", 128'(in_ready), 128'(5'h1F));
    tick;
    chk("pt_drained", 128'(out_valid), 128'(5'h00));

    // back-pressure on ch3
    out_ready = 5'b10111;
    in_valid = 5'b01000; set_data(3, 128'hA1);
    tick;
    set_data(3, 128'hA2);
    #1;
    chk("bp_ready_second_push", 128'(in_ready[3]), 128'(1'b1));
    tick;
    in_valid = '0;
    #1;
    chk("bp_in_ready_full", 128'(in_ready[3]), 128'(1'b0));
    out_ready = 5'h1F;
    #1;
    chk("bp_first_valid", 128'(out_valid[3]), 128'(1'b1));
    chk("bp_first_data", od(3), 128'hA1);
    tick;
    chk("bp_second_valid", 128'(out_valid[3]), 128'(1'b1));
    chk("bp_second_data", od(3), 128'hA2);
    chk("bp_in_ready_back", 128'(in_ready[3]), 128'(1'b1));
    tick;
    chk("bp_empty", 128'(out_valid[3]), 128'(1'b0));

    // pause with ch1 full; ch0 offers a payload that must be ignored
    out_ready = 5'b11101;
    in_valid = 5'b00010; set_data(1, 128'hB0);
    tick;
    set_data(1, 128'hB1);
    tick;
    pausereq = 1'b1; out_ready = 5'h1F;
    in_valid = 5'b00001; set_data(0, 128'hEE);
    #1;
    chk("pause_out_valid", 128'(out_valid), 128'(5'h00));
    chk("pause_in_ready", 128'(in_ready), 128'(5'h00));
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("pause_hold_valid", 128'(out_valid), 128'(5'h00));
      chk("pause_hold_ready", 128'(in_ready), 128'(5'h00));
    end
    pausereq = 1'b0; in_valid = '0;
    #1;
    chk("unpause_valid0", 128'(out_valid), 128'(5'b00010));
    chk("unpause_data0", od(1), 128'hB0);
    tick;
    chk("unpause_valid1", 128'(out_valid), 128'(5'b00010));
    chk("unpause_data1", od(1), 128'hB1);
    tick;
    chk("unpause_empty", 128'(out_valid), 128'(5'h00));

    // flush together with pause kills held data and ignores inputs
    out_ready = 5'b11011;
    in_valid = 5'b00100; set_data(2, 128'hC0);
    tick;
    in_valid = '0;
    #1;
    chk("fl_loaded", 128'(out_valid), 128'(5'b00100));
    flush = 1'b1; pausereq = 1'b1; in_valid = 5'h1F;
    for (int i = 0; i < N; i++) set_data(i, 128'(8'hF0 + i));
    #1;
    chk("fl_in_ready", 128'(in_ready), 128'(5'h00));
    chk("fl_out_valid", 128'(out_valid), 128'(5'h00));
    tick;
    flush = 1'b0; pausereq = 1'b0; in_valid = '0;
    #1;
    chk("fl_after_valid", 128'(out_valid), 128'(5'h00));
    chk("fl_after_ready", 128'(in_ready), 128'(5'h1F));

    // reset with every channel full
    out_ready = '0;
    in_valid = 5'h1F;
    for (int i = 0; i < N; i++) set_data(i, 128'(8'hD0 + i));
    tick;
    for (int i = 0; i < N; i++) set_data(i, 128'(8'hD8 + i));
    tick;
    in_valid = '0;
    #1;
    chk("mr_full_ready", 128'(in_ready), 128'(5'h00));
    chk("mr_full_valid", 128'(out_valid), 128'(5'h1F));
    chk("mr_full_data4", od(4), 128'hD4);
    rst = 1'b1;
    #1;
    chk("mr_rst_valid", 128'(out_valid), 128'(5'h00));
    chk("mr_rst_ready", 128'(in_ready), 128'(5'h00));
    chk("mr_rst_data", 128'(out_data == '0), 128'(1'b1));
    tick;
    rst = 1'b0;
    #1;
    chk("mr_after_valid", 128'(out_valid), 128'(5'h00));
    chk("mr_after_data", 128'(out_data == '0), 128'(1'b1));
    chk("mr_after_ready", 128'(in_ready), 128'(5'h1F));
    out_ready = 5'h1F;
    tick;
    chk("mr_no_ghost", 128'(out_valid), 128'(5'h00));

`ifdef DISPATCH_IQ_PIPE_PERF_EN
    // back-pressure counter: 7 stalled cycles on ch2, 2 of them paused
    chk("perf_cleared", 128'(perf_bp_cnt), 128'(32'd0));
    out_ready = 5'b11011;
    in_valid = 5'b00100; set_data(2, 128'hE0);
    tick;
    in_valid = '0;
    for (int k = 0; k < 7; k++) begin
      pausereq = (k == 2) || (k == 3);
      tick;
    end
    pausereq = 1'b0;
    #1;
    chk("perf_count", 128'(perf_bp_cnt), 128'(32'd5));
    chk("perf_ch2_held", 128'(out_valid[2]), 128'(1'b1));
    out_ready = 5'h1F;
    tick;
    chk("perf_after_drain", 128'(perf_bp_cnt), 128'(32'd5));
    chk("perf_drained", 128'(out_valid), 128'(5'h00));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
